// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and widths for the processor pipeline stage registers.
//   em_ctrl_t   : EX/MEM control bundle (pc_src, reg_write, mem_to_reg,
//                 mem_write). The stage control width is its bit count.
//   EM_DATA_W   : EX/MEM data payload = ALU result + store data + dest reg.
//   STALL_CNT_W : default width of the per-stage stall counter.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // EX/MEM control bundle, MSB first.
    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } em_ctrl_t;

    localparam int EM_CTRL_W   = $bits(em_ctrl_t);

    // EX/MEM payload fields.
    localparam int EM_ALU_W    = 32;
    localparam int EM_WDATA_W  = 32;
    localparam int EM_RD_W     = 4;
    localparam int EM_DATA_W   = EM_ALU_W + EM_WDATA_W + EM_RD_W;

    localparam int STALL_CNT_W = 16;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage entry of a pipeline stage: valid bit, control field, data field.
// Updates on the falling edge of i_clk; asynchronous active-low reset.
//   i_clk    in   stage clock (falling edge active)
//   i_rst_n  in   asynchronous reset, active low; clears every register
//   i_clr    in   clear valid and control (data is retained); beats i_load
//   i_load   in   capture i_ctrl/i_data and set valid
//   i_ctrl   in   control field to capture
//   i_data   in   data field to capture
//   o_valid  out  entry holds a beat
//   o_ctrl   out  held control field (zero whenever o_valid is 0)
//   o_data   out  held data field
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EM_CTRL_W,
    parameter int DATA_W = EM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Valid and control: clear wins over load so a squashed beat never lands.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{1'b0}};
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end else begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
        end
    end

    // Data only moves on a real load; a clear leaves the last payload in place.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= {DATA_W{1'b0}};
        end else if (i_load && !i_clr) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready flow control, flush,
// optional skid entry and a saturating stall counter. All registers update on
// the falling edge of CLK; RESET_N is asynchronous, active low.
//
// Build option: define PIPE_SKID_EN to add the skid entry. in_ready then comes
// straight from a register (capacity 2). Without it, in_ready is combinational
// from out_ready (capacity 1).
//
// Ports:
//   CLK        in   stage clock (falling edge active)
//   RESET_N    in   asynchronous reset, active low
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat this cycle
//   in_ctrl    in   upstream control bits
//   in_data    in   upstream data
//   flush      in   synchronous squash of all held beats
//   out_valid  out  beat held for downstream
//   out_ready  in   downstream accepts the beat
//   out_ctrl   out  held control bits, zero whenever out_valid is 0
//   out_data   out  held data (kept across flush and drain)
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EM_CTRL_W,
    parameter int DATA_W = EM_DATA_W,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_load;
    logic              w_main_clr;
    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic [DATA_W-1:0] w_main_ld_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic              w_main_take;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_clr;

    // Two-entry steering. The skid only fills while main is held, so a set
    // skid always implies a full main; an older skid beat drains first.
    always_comb begin
        w_main_take    = ~w_main_valid | w_out_fire;
        w_main_ld_ctrl = in_ctrl;
        w_main_ld_data = in_data;
        if (w_skid_valid) begin
            w_main_ld_ctrl = w_skid_ctrl;
            w_main_ld_data = w_skid_data;
        end else begin
            w_main_ld_ctrl = in_ctrl;
            w_main_ld_data = in_data;
        end
        w_main_load = w_main_take & (w_skid_valid | w_in_fire);
        w_main_clr  = flush | (w_out_fire & ~w_main_load);
        w_skid_load = w_in_fire & w_main_valid & ~out_ready;
        w_skid_clr  = flush | (w_main_take & w_skid_valid);
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_clr   (w_skid_clr),
        .i_load  (w_skid_load),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Registered ready: no combinational path from out_ready.
    assign in_ready = ~w_skid_valid;
`else
    // Single-entry steering: a simultaneous accept replaces the drained beat.
    always_comb begin
        w_main_ld_ctrl = in_ctrl;
        w_main_ld_data = in_data;
        w_main_load    = w_in_fire;
        w_main_clr     = flush | (w_out_fire & ~w_in_fire);
    end

    // Accept when empty or when the held beat leaves this cycle.
    assign in_ready = ~w_main_valid | out_ready;
`endif

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_clr   (w_main_clr),
        .i_load  (w_main_load),
        .i_ctrl  (w_main_ld_ctrl),
        .i_data  (w_main_ld_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    // Stall counter: counts held-but-refused cycles, sticks at all-ones.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg
